// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int C_NUM_REQ     = 4;
  localparam int C_DATA_WIDTH  = 8;
  localparam int C_BURST_WIDTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after last+1, wrapping.
module rr_arbiter #(
  parameter  int P_NUM_REQ = 4,
  localparam int ID_W      = $clog2(P_NUM_REQ)
) (
  input  logic [P_NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]      i_last,
  output logic [ID_W-1:0]      o_winner,
  output logic                 o_any
);

  logic [ID_W-1:0] idx;

  // Walk the requesters starting just after the previous winner; the first hit wins.
  always_comb begin
    o_winner = '0;
    o_any    = 1'b0;
    idx      = '0;
    for (int i = 1; i <= P_NUM_REQ; i++) begin
      idx = ID_W'((int'(i_last) + i) % P_NUM_REQ);
      if (!o_any && i_req[idx]) begin
        o_any    = 1'b1;
        o_winner = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a single FIFO.
// Build option: define FIFO_ARB_BURST_EN to allow multi-beat grants sized by
// i_cfg_burst_len; otherwise every grant is exactly one beat and the config
// port is ignored.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no grant held; arbitrate whenever a request is up and FIFO has room
//   ST_GRANT | one requester owns the FIFO until its burst ends or it drops valid
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int P_NUM_REQ     = C_NUM_REQ,
  parameter  int P_DATA_WIDTH  = C_DATA_WIDTH,
  parameter  int P_BURST_WIDTH = C_BURST_WIDTH,
  localparam int ID_W          = $clog2(P_NUM_REQ)
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [P_NUM_REQ-1:0]              i_req_valid,
  input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_req_data,
  output logic [P_NUM_REQ-1:0]              o_req_ready,
  input  logic                              i_fifo_full,
  output logic                              o_fifo_wren,
  output logic [P_DATA_WIDTH-1:0]           o_fifo_wdata,
  input  logic [P_BURST_WIDTH-1:0]          i_cfg_burst_len,
  output logic                              o_grant_valid,
  output logic [ID_W-1:0]                   o_grant_id
);

  localparam int              CNT_W    = P_BURST_WIDTH + 1;
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(P_NUM_REQ - 1);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [ID_W-1:0] rr_winner;
  logic            rr_any;
  logic            gnt_req_valid;
  logic [P_DATA_WIDTH-1:0] req_data [P_NUM_REQ];

`ifdef FIFO_ARB_BURST_EN
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] burst_len_q, burst_len_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^i_cfg_burst_len;
`endif

  for (genvar k = 0; k < P_NUM_REQ; k++) begin : g_slice
    assign req_data[k] = i_req_data[k*P_DATA_WIDTH +: P_DATA_WIDTH];
  end

  rr_arbiter #(.P_NUM_REQ(P_NUM_REQ)) u_rr (
    .i_req    (i_req_valid),
    .i_last   (last_grant_q),
    .o_winner (rr_winner),
    .o_any    (rr_any)
  );

  assign o_grant_valid = (state_q == ST_GRANT);
  assign o_grant_id    = grant_id_q;

  // Beat handshake: only the granted requester sees ready, and only while the FIFO has room.
  always_comb begin
    o_req_ready   = '0;
    gnt_req_valid = i_req_valid[grant_id_q];
    if (state_q == ST_GRANT && !i_fifo_full) begin
      o_req_ready[grant_id_q] = 1'b1;
    end
    o_fifo_wren  = (state_q == ST_GRANT) && !i_fifo_full && gnt_req_valid;
    o_fifo_wdata = req_data[grant_id_q];
  end

  // Next-state: arbitrate in IDLE, count beats in GRANT, leave on burst end or valid drop.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
`ifdef FIFO_ARB_BURST_EN
    beat_cnt_d   = beat_cnt_q;
    burst_len_d  = burst_len_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rr_any && !i_fifo_full) begin
          state_d      = ST_GRANT;
          grant_id_d   = rr_winner;
          last_grant_d = rr_winner;
`ifdef FIFO_ARB_BURST_EN
          beat_cnt_d   = '0;
          // A zero length would never terminate, so it is read as one beat.
          burst_len_d  = (i_cfg_burst_len == '0) ? CNT_W'(1) : CNT_W'(i_cfg_burst_len);
`endif
        end
      end
      ST_GRANT: begin
        if (!gnt_req_valid) begin
          state_d = ST_IDLE;
        end else if (o_fifo_wren) begin
`ifdef FIFO_ARB_BURST_EN
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_d == burst_len_q) begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and grant registers; reset points the round-robin at requester 0 first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= LAST_RST;
`ifdef FIFO_ARB_BURST_EN
      beat_cnt_q   <= '0;
      burst_len_q  <= CNT_W'(1);
`endif
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
`ifdef FIFO_ARB_BURST_EN
      beat_cnt_q   <= beat_cnt_d;
      burst_len_q  <= burst_len_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter. Expected burst lengths follow the
// FIFO_ARB_BURST_EN build option so the same bench covers both builds.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int BW = 4;
  localparam int IW = 2;

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic [NR-1:0]      i_req_valid;
  logic [NR*DW-1:0]   i_req_data;
  logic [NR-1:0]      o_req_ready;
  logic               i_fifo_full;
  logic               o_fifo_wren;
  logic [DW-1:0]      o_fifo_wdata;
  logic [BW-1:0]      i_cfg_burst_len;
  logic               o_grant_valid;
  logic [IW-1:0]      o_grant_id;

  int n_cmp = 0;
  int n_err = 0;
  int seq [NR];

  fifo_wr_arbiter #(.P_NUM_REQ(NR), .P_DATA_WIDTH(DW), .P_BURST_WIDTH(BW)) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_req_valid     (i_req_valid),
    .i_req_data      (i_req_data),
    .o_req_ready     (o_req_ready),
    .i_fifo_full     (i_fifo_full),
    .o_fifo_wren     (o_fifo_wren),
    .o_fifo_wdata    (o_fifo_wdata),
    .i_cfg_burst_len (i_cfg_burst_len),
    .o_grant_valid   (o_grant_valid),
    .o_grant_id      (o_grant_id)
  );

  always #5 i_clk = ~i_clk;

  function automatic int eff_burst(input int cfg);
`ifdef FIFO_ARB_BURST_EN
    return (cfg == 0) ? 1 : cfg;
`else
    return 1;
`endif
  endfunction

  function automatic logic [DW-1:0] exp_data(input int id);
    logic [3:0] a;
    logic [3:0] s;
    a = 4'(id);
    s = 4'(seq[id]);
    return {a, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each requester presents {id, beats_accepted_so_far}, so order and source are visible.
  task automatic drive_data();
    for (int k = 0; k < NR; k++) begin
      logic [3:0] kk;
      logic [3:0] ss;
      kk = 4'(k);
      ss = 4'(seq[k]);
      i_req_data[k*DW +: DW] = {kk, ss};
    end
  endtask

  task automatic step();
    logic          wr;
    logic [IW-1:0] wid;
    wr  = o_fifo_wren;
    wid = o_grant_id;
    @(posedge i_clk);
    #1;
    if (wr) seq[wid]++;
    drive_data();
  endtask

  // Called with the DUT in IDLE and inputs set so that 'id' wins this cycle.
  task automatic run_grant(input int id, input int beats, input int stall_at,
                           input int stall_cyc, input bit drop, input bit clear);
    #1;
    chk("arb_idle_gv", 32'(o_grant_valid), 0);
    chk("arb_idle_wren", 32'(o_fifo_wren), 0);
    step();
    for (int b = 0; b < beats; b++) begin
      if (b == stall_at && stall_cyc > 0) begin
        i_fifo_full = 1'b1;
        for (int s = 0; s < stall_cyc; s++) begin
          #1;
          chk("stall_gv", 32'(o_grant_valid), 1);
          chk("stall_id", 32'(o_grant_id), id);
          chk("stall_wren", 32'(o_fifo_wren), 0);
          chk("stall_ready", 32'(o_req_ready), 0);
          step();
        end
        i_fifo_full = 1'b0;
      end
      #1;
      chk("beat_gv", 32'(o_grant_valid), 1);
      chk("beat_id", 32'(o_grant_id), id);
      chk("beat_wren", 32'(o_fifo_wren), 1);
      chk("beat_ready", 32'(o_req_ready), 1 << id);
      chk("beat_data", 32'(o_fifo_wdata), 32'(exp_data(id)));
      step();
    end
    if (drop) begin
      i_req_valid[id] = 1'b0;
      #1;
      chk("drop_gv", 32'(o_grant_valid), 1);
      chk("drop_wren", 32'(o_fifo_wren), 0);
      step();
    end
    if (clear) i_req_valid = '0;
    #1;
    chk("end_gv", 32'(o_grant_valid), 0);
  endtask

  initial begin
    for (int k = 0; k < NR; k++) seq[k] = 0;
    i_rst_n         = 1'b0;
    i_req_valid     = '0;
    i_fifo_full     = 1'b0;
    i_cfg_burst_len = 4'd4;
    i_req_data      = '0;
    drive_data();

    // reset values
    #12;
    chk("rst_gv", 32'(o_grant_valid), 0);
    chk("rst_id", 32'(o_grant_id), 0);
    chk("rst_wren", 32'(o_fifo_wren), 0);
    chk("rst_ready", 32'(o_req_ready), 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    step();
    chk("no_req_gv", 32'(o_grant_valid), 0);

    // all requesting: 0,1,2,3 in order, idle cycle between grants
    i_cfg_burst_len = 4'd4;
    i_req_valid     = 4'b1111;
    run_grant(0, eff_burst(4), -1, 0, 1'b0, 1'b0);
    run_grant(1, eff_burst(4), -1, 0, 1'b0, 1'b0);
    run_grant(2, eff_burst(4), -1, 0, 1'b0, 1'b0);
    run_grant(3, eff_burst(4), -1, 0, 1'b0, 1'b1);
    step();

    // FIFO full stall inside a grant to requester 2
    i_cfg_burst_len = 4'd8;
    i_req_valid     = 4'b0100;
    run_grant(2, eff_burst(8), (eff_burst(8) > 3) ? 3 : 0, 5, 1'b0, 1'b1);

    // requester 1 drops valid mid-burst, requester 2 follows
    i_cfg_burst_len = 4'd4;
    i_req_valid     = 4'b0110;
    run_grant(1, (eff_burst(4) > 2) ? 2 : 0, -1, 0, 1'b1, 1'b0);
    run_grant(2, eff_burst(4), -1, 0, 1'b0, 1'b1);

    // zero length reads as one beat; length 7
    i_cfg_burst_len = 4'd0;
    i_req_valid     = 4'b1111;
    run_grant(3, eff_burst(0), -1, 0, 1'b0, 1'b0);
    run_grant(0, eff_burst(0), -1, 0, 1'b0, 1'b1);
    i_cfg_burst_len = 4'd7;
    i_req_valid     = 4'b0010;
    run_grant(1, eff_burst(7), -1, 0, 1'b0, 1'b1);

    // full in IDLE blocks arbitration, then requester 3 wins
    i_cfg_burst_len = 4'd2;
    i_req_valid     = 4'b1000;
    i_fifo_full     = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("full_idle_gv", 32'(o_grant_valid), 0);
      step();
    end
    i_fifo_full = 1'b0;
    run_grant(3, eff_burst(2), -1, 0, 1'b0, 1'b1);

    // asynchronous reset in the middle of a grant
    i_cfg_burst_len = 4'd4;
    i_req_valid     = 4'b0010;
    step();
    #1;
    chk("pre_rst_gv", 32'(o_grant_valid), 1);
    chk("pre_rst_id", 32'(o_grant_id), 1);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_gv", 32'(o_grant_valid), 0);
    chk("async_rst_wren", 32'(o_fifo_wren), 0);
    chk("async_rst_ready", 32'(o_req_ready), 0);
    chk("async_rst_id", 32'(o_grant_id), 0);
    @(posedge i_clk);
    #1;
    i_rst_n     = 1'b1;
    i_req_valid = 4'b1111;
    run_grant(0, eff_burst(4), -1, 0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter P_NUM_REQ, default 4, number of write requesters (2..16).
REQ-002 SHALL have parameter P_DATA_WIDTH, default 8, beat width.
REQ-003 SHALL have parameter P_BURST_WIDTH, default 4, width of burst-length config.
REQ-004 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_req_valid  input  P_NUM_REQ  per-requester beat valid.
REQ-007 SHALL have port i_req_data  input  P_NUM_REQ*P_DATA_WIDTH  requester k in bits [k*P_DATA_WIDTH +: P_DATA_WIDTH].
REQ-008 SHALL have port o_req_ready  output  P_NUM_REQ  per-requester beat accept.
REQ-009 SHALL have port i_fifo_full  input  1  downstream FIFO full flag.
REQ-010 SHALL have port o_fifo_wren  output  1  FIFO write enable.
REQ-011 SHALL have port o_fifo_wdata  output  P_DATA_WIDTH  FIFO write data.
REQ-012 SHALL have port i_cfg_burst_len  input  P_BURST_WIDTH  beats per grant; 0 treated as 1.
REQ-013 SHALL have port o_grant_valid  output  1  a requester currently holds the grant.
REQ-014 SHALL have port o_grant_id  output  $clog2(P_NUM_REQ)  index of the granted requester.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-016 In IDLE with any i_req_valid set and i_fifo_full low, SHALL register a round-robin winner into o_grant_id, set o_grant_valid, go to GRANT; one-cycle arbitration latency.
REQ-017 Round-robin search SHALL start at (last_grant+1) mod P_NUM_REQ; last_grant updates on each new grant.
REQ-018 In IDLE with i_fifo_full high, SHALL stay in IDLE and issue no grant.
REQ-019 o_req_ready[k] SHALL be 1 only when state is GRANT, k == o_grant_id, and i_fifo_full is low; all other bits 0.
REQ-020 o_fifo_wren SHALL equal i_req_valid[o_grant_id] & o_req_ready[o_grant_id], combinationally; o_fifo_wdata SHALL be the granted requester's data slice.
REQ-021 A beat counter SHALL increment on each o_fifo_wren in GRANT and clear on entry to GRANT.
REQ-022 GRANT SHALL return to IDLE after the beat that makes count equal the effective burst length, clearing o_grant_valid next cycle.
REQ-023 GRANT SHALL return to IDLE on any cycle the granted requester's i_req_valid is low (no write that cycle).
REQ-024 i_fifo_full high in GRANT SHALL stall: no write, counter held, grant held.
REQ-025 i_cfg_burst_len SHALL be sampled on entry to GRANT; changes mid-burst take effect next grant.
REQ-026 Counter SHALL be P_BURST_WIDTH+1 bits wide; no wrap within a burst.

Reset
REQ-027 On i_rst_n low: state IDLE, o_grant_valid 0, o_grant_id 0, last_grant P_NUM_REQ-1 (requester 0 first), beat counter 0, o_req_ready 0, o_fifo_wren 0.
REQ-028 Reset asserted mid-burst SHALL abort the burst immediately; no partial state survives.

Configuration
REQ-029 Macro FIFO_ARB_BURST_EN defined: burst length per REQ-012/022/025.
REQ-030 Macro FIFO_ARB_BURST_EN undefined: effective burst length fixed at 1, i_cfg_burst_len ignored but port retained, counter logic removed.

Structure
REQ-031 Package fifo_arb_pkg SHALL hold the FSM state enum typedef and the default parameter constants.
REQ-032 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs: request vector, last_grant; outputs: winner index, any-request).

Verification
REQ-033 Reset then valid=4'b1111, burst_len=4, full=0 -> grants 0,1,2,3 in order, each exactly 4 wren beats, one idle cycle between grants.
REQ-034 Grant to req 2, burst_len=8, full high after beat 3 for 5 cycles -> wren 0 and ready 0 during stall; burst completes 8 beats total, data order preserved.
REQ-035 Grant to req 1, burst_len=4, valid[1] drops after beat 2 -> FSM to IDLE, 2 beats written, next grant to req 2 if requesting.
REQ-036 burst_len=0 with macro defined -> each grant writes exactly 1 beat; macro undefined with burst_len=7 -> each grant writes 1 beat.
REQ-037 Only req 3 valid, full=1 in IDLE -> no grant; full=0 -> grant to 3 next cycle.
REQ-038 i_rst_n pulsed low at beat 2 of burst -> o_grant_valid, o_fifo_wren, o_req_ready 0 asynchronously; after release first grant goes to req 0.
